mod_n_seq_checker: RTL and testbench

- Receive-side companion to the team's mod-N up counter.
- Samples a count stream (0..N-1, wrapping to 0) and verifies it follows the legal mod-N sequence.
- Locks onto the stream, flags sequence breaks, and keeps error and wrap statistics.
- Sits on the consumer side of any link carrying a mod-N sequence or frame count.

---
 rtl/mod_n_seq_checker_if.sv | 41 ++++
 rtl/mod_n_seq_checker.sv | 132 +++++++++++++
 tb/tb_mod_n_seq_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mod_n_seq_checker_if.sv
// ----------------------------------------------------------------------------
// mod_n_seq_checker_if
//   Bundles the sample stream and the status/statistics outputs of the mod-N
//   sequence checker.
//
//   Signals:
//     in_valid   - in_count carries a sample this cycle
//     in_count   - received count value (WIDTH bits)
//     locked     - checker is locked onto the stream
//     seq_err    - one-cycle pulse, sequence break while locked
//     err_count  - saturating count of seq_err events (ERR_W bits)
//     wrap_pulse - one-cycle pulse, correct N-1 -> 0 seen while locked
//     wrap_count - wrapping count of wrap_pulse events (WRAP_W bits)
//
//   Modports:
//     master - stream source / status consumer
//     slave  - the checker itself
// ----------------------------------------------------------------------------
interface mod_n_seq_checker_if #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    logic              in_valid;
    logic [WIDTH-1:0]  in_count;
    logic              locked;
    logic              seq_err;
    logic [ERR_W-1:0]  err_count;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output in_valid, in_count,
        input  locked, seq_err, err_count, wrap_pulse, wrap_count
    );

    modport slave (
        input  in_valid, in_count,
        output locked, seq_err, err_count, wrap_pulse, wrap_count
    );
endinterface

// File: rtl/mod_n_seq_checker.sv
// ----------------------------------------------------------------------------
// mod_n_seq_checker
//   Receive-side checker for a mod-N count stream (0..N-1, wrapping to 0).
//   Acquires a reference, declares lock after LOCK_CNT further consecutive
//   correct samples, then flags every sequence break and counts errors
//   (saturating) and wraps (rolling over). All outputs are registered, so
//   each sample's effect is visible one clock after its sampling edge.
//
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset
//     bus - mod_n_seq_checker_if.slave (sample stream in, status out)
// ----------------------------------------------------------------------------
module mod_n_seq_checker #(
    parameter int N        = 15,
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    mod_n_seq_checker_if.slave  bus
);
    // match_cnt must be able to hold LOCK_CNT itself.
    localparam int MW = $clog2(LOCK_CNT + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic              have_ref;
    logic [MW-1:0]     match_cnt;
    logic [WIDTH-1:0]  expected;
    logic              locked_q;
    logic              seq_err_q;
    logic              wrap_pulse_q;
    logic [ERR_W-1:0]  err_count_q;
    logic [WRAP_W-1:0] wrap_count_q;

    logic in_range;
    logic hit;

    function automatic logic [WIDTH-1:0] next_of(input logic [WIDTH-1:0] x);
        return (x == WIDTH'(N - 1)) ? '0 : x + WIDTH'(1);
    endfunction

    // Widen by one bit so the compare stays meaningful when 2^WIDTH == N.
    assign in_range = ({1'b0, bus.in_count} < (WIDTH + 1)'(N));
    // expected is always in range, so a hit implies an in-range sample.
    assign hit      = (bus.in_count == expected);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            have_ref     <= 1'b0;
            match_cnt    <= '0;
            expected     <= '0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            // Pulses last exactly one cycle; idle cycles leave them low.
            seq_err_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;

            if (bus.in_valid) begin
                unique case (state)
                    HUNT: begin
                        if (!have_ref) begin
                            if (in_range) begin
                                expected  <= next_of(bus.in_count);
                                have_ref  <= 1'b1;
                                match_cnt <= '0;
                            end
                        end else if (hit) begin
                            expected  <= next_of(bus.in_count);
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (in_range) begin
                            // Silent resync onto the new value.
                            expected  <= next_of(bus.in_count);
                            match_cnt <= '0;
                        end else begin
                            have_ref  <= 1'b0;
                            match_cnt <= '0;
                        end
                    end

                    LOCKED: begin
                        if (hit) begin
                            expected <= next_of(bus.in_count);
                            if (bus.in_count == '0) begin
                                wrap_pulse_q <= 1'b1;
                                wrap_count_q <= wrap_count_q + 1'b1;
                            end
                        end else begin
                            seq_err_q <= 1'b1;
                            if (err_count_q != '1)
                                err_count_q <= err_count_q + 1'b1;
                            locked_q  <= 1'b0;
                            state     <= HUNT;
                            match_cnt <= '0;
                            // The breaking sample seeds reacquisition if usable.
                            have_ref  <= in_range;
                            if (in_range)
                                expected <= next_of(bus.in_count);
                        end
                    end

                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.locked     = locked_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.wrap_count = wrap_count_q;

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// ----------------------------------------------------------------------------
// tb_mod_n_seq_checker
//   Scoreboard bench for mod_n_seq_checker (N=15, LOCK_CNT=3, ERR_W=8).
//   The stimulus process drives samples at the falling edge and pushes the
//   hand-computed response for each into a queue; the monitor pops one entry
//   at every falling edge following a sampled (valid or reset) cycle.
// ----------------------------------------------------------------------------
module tb_mod_n_seq_checker;
    localparam int N        = 15;
    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 3;
    localparam int ERR_W    = 8;
    localparam int WRAP_W   = 16;

    typedef struct {
        logic              locked;
        logic              seq_err;
        logic              wrap_pulse;
        logic [ERR_W-1:0]  err_count;
        logic [WRAP_W-1:0] wrap_count;
    } exp_t;

    logic clk;
    logic rst;
    logic pend;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mod_n_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) bus ();

    mod_n_seq_checker #(
        .N(N), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W), .WRAP_W(WRAP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Marks cycles whose outputs carry a response to be scored.
    always @(posedge clk) pend <= bus.in_valid || rst;

    always @(negedge clk) begin
        exp_t e;
        if (pend === 1'b1) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("locked",     32'(bus.locked),     32'(e.locked));
                check("seq_err",    32'(bus.seq_err),    32'(e.seq_err));
                check("wrap_pulse", 32'(bus.wrap_pulse), 32'(e.wrap_pulse));
                check("err_count",  32'(bus.err_count),  32'(e.err_count));
                check("wrap_count", 32'(bus.wrap_count), 32'(e.wrap_count));
            end
        end else if (pend === 1'b0) begin
            check("idle_seq_err",    32'(bus.seq_err),    32'd0);
            check("idle_wrap_pulse", 32'(bus.wrap_pulse), 32'd0);
        end
    end

    task automatic push(input logic l, input logic s, input logic w,
                        input int ec, input int wc);
        exp_t e;
        e.locked     = l;
        e.seq_err    = s;
        e.wrap_pulse = w;
        e.err_count  = ERR_W'(ec);
        e.wrap_count = WRAP_W'(wc);
        sb.push_back(e);
    endtask

    task automatic send(input int v, input logic l, input logic s, input logic w,
                        input int ec, input int wc);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_count = WIDTH'(v);
        push(l, s, w, ec, wc);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset(input logic v, input int c);
        rst          = 1'b1;
        bus.in_valid = v;
        bus.in_count = WIDTH'(c);
        push(1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int x;
        int sat;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_count = '0;

        // Reset state
        do_reset(1'b0, 0);

        // Lock and wrap: reference 12, matches 13,14,0 -> locked after 0
        send(12, 0, 0, 0, 0, 0);
        send(13, 0, 0, 0, 0, 0);
        send(14, 0, 0, 0, 0, 0);
        send(0,  1, 0, 0, 0, 0);   // 0 matched in HUNT: no wrap
        send(1,  1, 0, 0, 0, 0);
        for (int v = 2; v <= 14; v++) send(v, 1, 0, 0, 0, 0);
        send(0,  1, 0, 1, 0, 1);   // first wrap while locked
        for (int v = 1; v <= 3; v++) send(v, 1, 0, 0, 0, 1);

        // Sequence break: expected 4, feed 5 (5 becomes the new reference)
        send(5, 0, 1, 0, 1, 1);
        send(6, 0, 0, 0, 1, 1);
        send(7, 0, 0, 0, 1, 1);
        send(8, 1, 0, 0, 1, 1);
        send(9, 1, 0, 0, 1, 1);

        // Out-of-range while locked, then out-of-range in HUNT
        send(15, 0, 1, 0, 2, 1);
        send(15, 0, 0, 0, 2, 1);   // no reference: ignored
        send(10, 0, 0, 0, 2, 1);
        send(11, 0, 0, 0, 2, 1);
        send(15, 0, 0, 0, 2, 1);   // drops reference, no seq_err
        send(12, 0, 0, 0, 2, 1);
        send(13, 0, 0, 0, 2, 1);
        send(14, 0, 0, 0, 2, 1);
        send(0,  1, 0, 0, 2, 1);
        for (int v = 1; v <= 14; v++) send(v, 1, 0, 0, 2, 1);
        send(0, 1, 0, 1, 2, 2);
        send(7, 0, 1, 0, 3, 2);    // break: expected 1
        send(8, 0, 0, 0, 3, 2);
        send(9, 0, 0, 0, 3, 2);
        send(10, 1, 0, 0, 3, 2);

        // Reset while locked (err=3, wrap=2), with a valid sample that is dropped
        do_reset(1'b1, 11);
        send(12, 0, 0, 0, 0, 0);   // would match had 11 been taken
        send(13, 0, 0, 0, 0, 0);
        send(14, 0, 0, 0, 0, 0);
        send(0,  1, 0, 0, 0, 0);

        // Plain reset, then lock with idle gaps between samples
        do_reset(1'b0, 0);
        send(3, 0, 0, 0, 0, 0);
        idle(1);
        send(4, 0, 0, 0, 0, 0);
        idle(5);
        send(5, 0, 0, 0, 0, 0);
        idle(2);
        send(6, 1, 0, 0, 0, 0);
        idle(4);
        send(7, 1, 0, 0, 0, 0);

        // Saturation: 300 break/relock rounds; expected value starts at 8
        e = 8;
        for (int i = 0; i < 300; i++) begin
            sat = (i + 1 > 255) ? 255 : i + 1;
            x = (e + 7) % N;
            send(x, 0, 1, 0, sat, 0);
            send((x + 1) % N, 0, 0, 0, sat, 0);
            send((x + 2) % N, 0, 0, 0, sat, 0);
            send((x + 3) % N, 1, 0, 0, sat, 0);
            e = (x + 4) % N;
        end

        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
